unidade_controle: RTL and testbench

Multi-cycle control unit directly upstream of the register-bank/ALU datapath block (BLOCO). It fetches 16-bit instruction words from an instruction memory using a req/valid handshake and decodes them. It drives the datapath's control inputs: write enable, three register selects, 5-bit ALU operation, register-bank reset and flag reset. It runs a fetch/decode/execute FSM with a program counter and HALT support.

---
 rtl/unidade_controle_pkg.sv | 34 +++
 rtl/unidade_controle_decodificador_instrucao.sv | 37 +++
 rtl/unidade_controle.sv | 131 +++++++++++++
 tb/tb_unidade_controle.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared types and constants for the multi-cycle control unit.
// Field positions are computed MSB-first from the word and register-select widths.
package unidade_controle_pkg;

    localparam int OP_W = 5;
    localparam logic [4:0] OP_HALT = 5'b11111;
    localparam logic [4:0] OP_CLRF = 5'b11110;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        FETCH   = 3'd2,
        DECODE  = 3'd3,
        EXECUTE = 3'd4,
        HALT    = 3'd5
    } state_t;

    function automatic int op_lsb(input int w);
        return w - OP_W;
    endfunction

    function automatic int sc_lsb(input int w, input int e);
        return w - OP_W - e;
    endfunction

    function automatic int sa_lsb(input int w, input int e);
        return w - OP_W - 2 * e;
    endfunction

    function automatic int sb_lsb(input int w, input int e);
        return w - OP_W - 3 * e;
    endfunction

endpackage

// File: rtl/unidade_controle_decodificador_instrucao.sv
// Combinational instruction splitter: op, SC, SA, SB from the top of the word.
// The low reserved bits carry no meaning and are deliberately dropped.
module decodificador_instrucao
    import unidade_controle_pkg::*;
#(
    parameter int bits_palavra  = 16,
    parameter int end_registros = 2
) (
    input  logic [bits_palavra-1:0]  ir,
    output logic [OP_W-1:0]          op,
    output logic [end_registros-1:0] sa,
    output logic [end_registros-1:0] sb,
    output logic [end_registros-1:0] sc,
    output logic                     is_halt,
    output logic                     is_clrf
);

    localparam int OP_LSB = op_lsb(bits_palavra);
    localparam int SC_LSB = sc_lsb(bits_palavra, end_registros);
    localparam int SA_LSB = sa_lsb(bits_palavra, end_registros);
    localparam int SB_LSB = sb_lsb(bits_palavra, end_registros);

    assign op      = ir[OP_LSB +: OP_W];
    assign sc      = ir[SC_LSB +: end_registros];
    assign sa      = ir[SA_LSB +: end_registros];
    assign sb      = ir[SB_LSB +: end_registros];
    assign is_halt = (op == OP_HALT);
    assign is_clrf = (op == OP_CLRF);

    generate
        if (SB_LSB > 0) begin : g_reserved
            logic unused_reserved_s;
            assign unused_reserved_s = ^ir[SB_LSB-1:0];
        end
    endgenerate

endmodule

// File: rtl/unidade_controle.sv
// Fetch/decode/execute control unit driving the register-bank/ALU datapath.
// Outputs are registered from the next state so they line up with the state they describe.
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter int bits_palavra  = 16,
    parameter int end_registros = 2,
    parameter int bits_pc       = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic                     instr_req,
    output logic [bits_pc-1:0]       instr_addr,
    input  logic                     instr_valid,
    input  logic [bits_palavra-1:0]  instr_data,
    output logic                     Hab_Escrita,
    output logic [end_registros-1:0] Sel_SA,
    output logic [end_registros-1:0] Sel_SB,
    output logic [end_registros-1:0] Sel_SC,
    output logic [4:0]               controleOperacao,
    output logic                     reset_Ban_Registros,
    output logic                     reset_Flags,
    output logic                     halted
);

    state_t                   state_r, next_s;
    logic [bits_pc-1:0]       pc_r;
    logic [bits_palavra-1:0]  ir_r;
    logic [end_registros-1:0] sel_sa_r, sel_sb_r, sel_sc_r;
    logic [OP_W-1:0]          op_r;
    logic                     req_r, hab_r, rban_r, rflags_r, halted_r;

    logic [OP_W-1:0]          op_s;
    logic [end_registros-1:0] sa_s, sb_s, sc_s;
    logic                     is_halt_s, is_clrf_s;
    logic                     fetch_done_s;
    logic                     req_nxt_s, hab_nxt_s, rban_nxt_s, rflags_nxt_s, halted_nxt_s;

    decodificador_instrucao #(
        .bits_palavra (bits_palavra),
        .end_registros(end_registros)
    ) u_dec (
        .ir     (ir_r),
        .op     (op_s),
        .sa     (sa_s),
        .sb     (sb_s),
        .sc     (sc_s),
        .is_halt(is_halt_s),
        .is_clrf(is_clrf_s)
    );

    // A fetch completes only on a real handshake while actually fetching.
    assign fetch_done_s = (state_r == FETCH) && req_r && instr_valid;

    // Next-state and next-output logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            INIT:    next_s = IDLE;
            IDLE:    if (start) next_s = FETCH; else next_s = IDLE;
            FETCH:   if (fetch_done_s) next_s = DECODE; else next_s = FETCH;
            DECODE:  if (is_halt_s) next_s = HALT; else next_s = EXECUTE;
            EXECUTE: next_s = FETCH;
            HALT:    next_s = HALT;
            default: next_s = INIT;
        endcase
        req_nxt_s    = (next_s == FETCH);
        halted_nxt_s = (next_s == HALT);
        hab_nxt_s    = (next_s == EXECUTE) && !is_clrf_s;
        rban_nxt_s   = (state_r == INIT);
        rflags_nxt_s = (state_r == INIT) || ((next_s == EXECUTE) && is_clrf_s);
    end

    // State and strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= INIT;
            req_r    <= 1'b0;
            hab_r    <= 1'b0;
            rban_r   <= 1'b0;
            rflags_r <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= next_s;
            req_r    <= req_nxt_s;
            hab_r    <= hab_nxt_s;
            rban_r   <= rban_nxt_s;
            rflags_r <= rflags_nxt_s;
            halted_r <= halted_nxt_s;
        end
    end

    // Program counter and instruction register, advanced on each completed fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r <= '0;
            ir_r <= '0;
        end else if (fetch_done_s) begin
            pc_r <= pc_r + {{(bits_pc-1){1'b0}}, 1'b1};
            ir_r <= instr_data;
        end
    end

    // Selects and operation latch in DECODE and hold until the next DECODE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_sa_r <= '0;
            sel_sb_r <= '0;
            sel_sc_r <= '0;
            op_r     <= '0;
        end else if (state_r == DECODE) begin
            sel_sa_r <= sa_s;
            sel_sb_r <= sb_s;
            sel_sc_r <= sc_s;
            op_r     <= op_s;
        end
    end

    assign instr_req           = req_r;
    assign instr_addr          = pc_r;
    assign Hab_Escrita         = hab_r;
    assign Sel_SA              = sel_sa_r;
    assign Sel_SB              = sel_sb_r;
    assign Sel_SC              = sel_sc_r;
    assign controleOperacao    = op_r;
    assign reset_Ban_Registros = rban_r;
    assign reset_Flags         = rflags_r;
    assign halted              = halted_r;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: vector table of instructions plus
// hand-written sequences for INIT, PC wrap, mid-EXECUTE reset and HALT.
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid = 1'b0;
    logic [15:0] instr_data = 16'h0000;
    logic        Hab_Escrita;
    logic [1:0]  Sel_SA, Sel_SB, Sel_SC;
    logic [4:0]  controleOperacao;
    logic        reset_Ban_Registros, reset_Flags, halted;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] word;
        int          delay;
        bit          pulse;
        logic [7:0]  addr;
        logic [4:0]  op;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [1:0]  sc;
        logic        hab;
        logic        rf;
    } vec_t;

    vec_t vecs [6];

    unidade_controle dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .instr_req          (instr_req),
        .instr_addr         (instr_addr),
        .instr_valid        (instr_valid),
        .instr_data         (instr_data),
        .Hab_Escrita        (Hab_Escrita),
        .Sel_SA             (Sel_SA),
        .Sel_SB             (Sel_SB),
        .Sel_SC             (Sel_SC),
        .controleOperacao   (controleOperacao),
        .reset_Ban_Registros(reset_Ban_Registros),
        .reset_Flags        (reset_Flags),
        .halted             (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] pack_out();
        return {Hab_Escrita, Sel_SA, Sel_SB, Sel_SC, controleOperacao,
                reset_Ban_Registros, reset_Flags, halted, instr_req, instr_addr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one instruction; returns at the negedge of its EXECUTE (or post-DECODE) cycle.
    task automatic do_instr(input vec_t v);
        int n = 0;
        while (!instr_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req_seen", {31'd0, instr_req}, 32'd1);
        chk("fetch_addr", {24'd0, instr_addr}, {24'd0, v.addr});
        for (int d = 0; d < v.delay; d++) begin
            @(negedge clk);
            chk("wait_req_held", {31'd0, instr_req}, 32'd1);
            chk("wait_addr_stable", {24'd0, instr_addr}, {24'd0, v.addr});
        end
        instr_valid = 1'b1;
        instr_data  = v.word;
        @(negedge clk);
        if (v.pulse) begin
            instr_valid = 1'b1;
            instr_data  = ~v.word;
        end else begin
            instr_valid = 1'b0;
        end
        chk("decode_req_low", {31'd0, instr_req}, 32'd0);
        chk("decode_hab_low", {31'd0, Hab_Escrita}, 32'd0);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("exec_hab", {31'd0, Hab_Escrita}, {31'd0, v.hab});
        chk("exec_rflags", {31'd0, reset_Flags}, {31'd0, v.rf});
        chk("exec_sel", {26'd0, Sel_SA, Sel_SB, Sel_SC}, {26'd0, v.sa, v.sb, v.sc});
        chk("exec_op", {27'd0, controleOperacao}, {27'd0, v.op});
        chk("exec_req_low", {31'd0, instr_req}, 32'd0);
    endtask

    initial begin
        vec_t w;
        int   n;
        vecs[0] = '{16'b00001_11_01_10_00000, 0, 1'b0, 8'd0, 5'b00001, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0};
        vecs[1] = '{16'b00101_00_10_11_00000, 3, 1'b1, 8'd1, 5'b00101, 2'd2, 2'd3, 2'd0, 1'b1, 1'b0};
        vecs[2] = '{16'hF000,                 0, 1'b0, 8'd2, 5'b11110, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1};
        vecs[3] = '{16'b10101_01_11_00_11111, 1, 1'b0, 8'd3, 5'b10101, 2'd3, 2'd0, 2'd1, 1'b1, 1'b0};
        vecs[4] = '{16'b00000_10_00_01_00000, 0, 1'b1, 8'd4, 5'b00000, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0};
        vecs[5] = '{16'b11101_11_11_11_00000, 2, 1'b0, 8'd5, 5'b11101, 2'd3, 2'd3, 2'd3, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_outputs", {8'd0, pack_out()}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("init_rban", {31'd0, reset_Ban_Registros}, 32'd1);
        chk("init_rflags", {31'd0, reset_Flags}, 32'd1);
        chk("init_req", {31'd0, instr_req}, 32'd0);
        @(negedge clk);
        chk("idle_outputs", {8'd0, pack_out()}, 32'd0);
        @(negedge clk);
        chk("idle_stays", {8'd0, pack_out()}, 32'd0);

        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_instr(vecs[i]);
            if (i == 0) start = 1'b0;
        end

        // Remaining ALU instructions up to address 255, then the fetch address wraps.
        for (int a = 6; a < 256; a++) begin
            w.op    = 5'(a % 29);
            w.sc    = 2'(a % 4);
            w.sa    = 2'((a / 4) % 4);
            w.sb    = 2'((a / 16) % 4);
            w.word  = {w.op, w.sc, w.sa, w.sb, 5'b00000};
            w.delay = 0;
            w.pulse = 1'b0;
            w.addr  = 8'(a);
            w.hab   = 1'b1;
            w.rf    = 1'b0;
            do_instr(w);
        end

        // Wrapped fetch at address 0; reset asserted mid-EXECUTE.
        w = '{16'b00011_01_10_11_00000, 0, 1'b0, 8'd0, 5'b00011, 2'd2, 2'd3, 2'd1, 1'b1, 1'b0};
        do_instr(w);
        start = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_hab", {31'd0, Hab_Escrita}, 32'd0);
        chk("async_reset_outputs", {8'd0, pack_out()}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reinit_rban", {31'd0, reset_Ban_Registros}, 32'd1);
        chk("reinit_rflags", {31'd0, reset_Flags}, 32'd1);
        @(negedge clk);
        chk("reinit_rban_off", {31'd0, reset_Ban_Registros}, 32'd0);
        chk("refetch_req", {31'd0, instr_req}, 32'd1);
        chk("refetch_addr_zero", {24'd0, instr_addr}, 32'd0);

        // HALT word.
        instr_valid = 1'b1;
        instr_data  = 16'hF800;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("halt_decode_req", {31'd0, instr_req}, 32'd0);
        @(negedge clk);
        chk("halt_outputs", {8'd0, pack_out()},
            {8'd0, 1'b0, 2'd0, 2'd0, 2'd0, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1});
        n = 0;
        for (int i = 0; i < 8; i++) begin
            start       = i[0];
            instr_valid = 1'b1;
            @(negedge clk);
            if (halted !== 1'b1 || instr_req !== 1'b0 || Hab_Escrita !== 1'b0 || reset_Flags !== 1'b0)
                n++;
        end
        instr_valid = 1'b0;
        chk("halt_sticky", n, 32'd0);
        chk("halt_final_addr", {24'd0, instr_addr}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
